// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parameterised register file with soft clear; REGFILE_SCOREBOARD_EN adds pending-write scoreboard
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  output logic              ready
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_reg,
  output logic              rs1_busy,
  output logic              rs2_busy
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CLR_START = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              ready_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr_live;
  logic wr_commit;
  logic clr_we;

  // wr_live drives the bypass; a same-cycle clear still drops the store itself
  assign wr_live   = regWrite && (state_q == READY) && !((ZERO_REG != 0) && (writeReg == '0));
  assign wr_commit = wr_live && !clr_req;
  assign clr_we    = (state_q == CLEAR) && !rst;
  assign ready     = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= CLR_START;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        READY: begin
          if (clr_req) begin
            state_q   <= CLEAR;
            clr_cnt_q <= CLR_START;
            ready_q   <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_req) begin
            clr_cnt_q <= CLR_START;
          end else if (clr_cnt_q == CLR_LAST) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= CLEAR;
          clr_cnt_q <= CLR_START;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_commit) begin
      mem_q[writeReg] <= writeData;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (state_q == READY) begin
      if (wr_live && (writeReg == addr)) begin
        val = writeData;
      end else if (!((ZERO_REG != 0) && (addr == '0))) begin
        val = mem_q[addr];
      end
    end
    return val;
  endfunction

  always_comb begin
    rd1_o = read_port(rs1);
    rd2_o = read_port(rs2);
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Clear-before-set so an alloc and a write to the same entry leave it pending
  always_comb begin
    pending_d = pending_q;
    if ((state_q != READY) || clr_req) begin
      pending_d = '0;
    end else begin
      if (wr_commit) begin
        pending_d[writeReg] = 1'b0;
      end
      if (alloc_en && !((ZERO_REG != 0) && (alloc_reg == '0))) begin
        pending_d[alloc_reg] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rs1_busy = pending_q[rs1] && !(regWrite && (writeReg == rs1) && (state_q == READY));
  assign rs2_busy = pending_q[rs2] && !(regWrite && (writeReg == rs2) && (state_q == READY));
`endif

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - self-checking bench for reg_file_param (default parameters)
module tb_reg_file_param;

  logic        clk;
  logic        rst;
  logic        clr_req;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rd1_o;
  logic [31:0] rd2_o;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        ready;
`ifdef REGFILE_SCOREBOARD_EN
  logic        alloc_en;
  logic [4:0]  alloc_reg;
  logic        rs1_busy;
  logic        rs2_busy;
`endif

  int vectors;
  int errors;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  reg_file_param dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd1_o    (rd1_o),
    .rd2_o    (rd2_o),
    .regWrite (regWrite),
    .writeReg (writeReg),
    .writeData(writeData),
    .ready    (ready)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .alloc_en (alloc_en),
    .alloc_reg(alloc_reg),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cycles;
    logic [4:0] addrs [4];
    addrs = '{5'd0, 5'd1, 5'd5, 5'd31};
    rst = 1'b1; clr_req = 1'b0; regWrite = 1'b0; writeReg = '0; writeData = '0;
    rs1 = '0; rs2 = '0;
`ifdef REGFILE_SCOREBOARD_EN
    alloc_en = 1'b0; alloc_reg = '0;
`endif
    step();
    step();
    vectors++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", ready); end
    rs1 = 5'd5; rs2 = 5'd31; #1;
    vectors++;
    if (rd1_o !== 32'h0 || rd2_o !== 32'h0) begin
      errors++; $display("FAIL clear_read got=%h/%h want=0", rd1_o, rd2_o);
    end
    rst = 1'b0;
    cycles = 0;
    while (ready !== 1'b1 && cycles < 100) begin step(); cycles++; end
    vectors++;
    if (cycles != 31) begin errors++; $display("FAIL reset_clear_len got=%0d want=31", cycles); end
    foreach (addrs[i]) begin
      rs1 = addrs[i]; rs2 = addrs[i];
      exp_q.push_back(32'h0);
      #1;
      exp = exp_q.pop_front();
      vectors++;
      if (rd1_o !== exp || rd2_o !== exp) begin
        errors++; $display("FAIL reset_read x%0d got=%h/%h want=%h", addrs[i], rd1_o, rd2_o, exp);
      end
    end
  endtask

  task automatic test_write_read();
    rs1 = 5'd1; rs2 = 5'd2;
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    step();
    regWrite = 1'b0; rs1 = 5'd5; rs2 = 5'd5; #1;
    exp = exp_q.pop_front();
    vectors++;
    if (rd1_o !== exp || rd2_o !== exp) begin
      errors++; $display("FAIL write_read got=%h/%h want=%h", rd1_o, rd2_o, exp);
    end
  endtask

  task automatic test_bypass_x0();
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h12345678; rs1 = 5'd7; rs2 = 5'd7;
    exp_q.push_back(32'h12345678);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (rd1_o !== exp || rd2_o !== exp) begin
      errors++; $display("FAIL bypass got=%h/%h want=%h", rd1_o, rd2_o, exp);
    end
    step();
    writeReg = 5'd0; writeData = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd0;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (rd1_o !== exp || rd2_o !== exp) begin
      errors++; $display("FAIL x0_bypass got=%h/%h want=%h", rd1_o, rd2_o, exp);
    end
    step();
    regWrite = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (rd2_o !== exp) begin errors++; $display("FAIL x0_read got=%h want=%h", rd2_o, exp); end
    rs1 = 5'd7; #1;
    vectors++;
    if (rd1_o !== 32'h12345678) begin errors++; $display("FAIL x7_read got=%h want=12345678", rd1_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      regWrite = 1'b1; writeReg = 5'(10 + i); writeData = $urandom;
      exp_q.push_back(writeData);
      step();
    end
    regWrite = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rs1 = 5'(10 + i); rs2 = 5'(10 + i); #1;
      exp = exp_q.pop_front();
      vectors++;
      if (rd1_o !== exp || rd2_o !== exp) begin
        errors++; $display("FAIL b2b x%0d got=%h/%h want=%h", 10 + i, rd1_o, rd2_o, exp);
      end
    end
  endtask

  task automatic test_soft_clear();
    int cycles;
    regWrite = 1'b1; writeReg = 5'd31; writeData = 32'hA5A5A5A5;
    step();
    regWrite = 1'b0; rs1 = 5'd31; #1;
    vectors++;
    if (rd1_o !== 32'hA5A5A5A5) begin errors++; $display("FAIL x31_pre got=%h want=a5a5a5a5", rd1_o); end
    clr_req = 1'b1; regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h1;
    step();
    clr_req = 1'b0; regWrite = 1'b0;
    vectors++;
    if (ready !== 1'b0) begin errors++; $display("FAIL clr_ready got=%b want=0", ready); end
    cycles = 0;
    while (ready !== 1'b1 && cycles < 100) begin
      regWrite = (cycles == 20); writeReg = 5'd2; writeData = 32'hBAD;
      step();
      cycles++;
    end
    regWrite = 1'b0;
    vectors++;
    if (cycles != 31) begin errors++; $display("FAIL clr_len got=%0d want=31", cycles); end
    rs1 = 5'd31; rs2 = 5'd3;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (rd1_o !== exp || rd2_o !== exp) begin
      errors++; $display("FAIL clr_read got=%h/%h want=%h", rd1_o, rd2_o, exp);
    end
    rs1 = 5'd2; #1;
    vectors++;
    if (rd1_o !== 32'h0) begin errors++; $display("FAIL clr_ignore_wr got=%h want=0", rd1_o); end
  endtask

  task automatic test_restart();
    int cycles;
    clr_req = 1'b1; step(); clr_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    cycles = 0;
    while (ready !== 1'b1 && cycles < 100) begin step(); cycles++; end
    vectors++;
    if (cycles != 31) begin errors++; $display("FAIL rst_restart got=%0d want=31", cycles); end
    clr_req = 1'b1; step(); clr_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    clr_req = 1'b1; step(); clr_req = 1'b0;
    cycles = 0;
    while (ready !== 1'b1 && cycles < 100) begin step(); cycles++; end
    vectors++;
    if (cycles != 31) begin errors++; $display("FAIL clr_restart got=%0d want=31", cycles); end
  endtask

`ifdef REGFILE_SCOREBOARD_EN
  task automatic test_scoreboard();
    alloc_en = 1'b1; alloc_reg = 5'd9;
    step();
    alloc_en = 1'b0; rs1 = 5'd9; #1;
    vectors++;
    if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_alloc got=%b want=1", rs1_busy); end
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h55; #1;
    vectors++;
    if (rs1_busy !== 1'b0 || rd1_o !== 32'h55) begin
      errors++; $display("FAIL sb_write got=%b/%h want=0/55", rs1_busy, rd1_o);
    end
    step();
    regWrite = 1'b0; #1;
    vectors++;
    if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_cleared got=%b want=0", rs1_busy); end
    alloc_en = 1'b1; alloc_reg = 5'd9; regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h66;
    step();
    alloc_en = 1'b0; regWrite = 1'b0; #1;
    vectors++;
    if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_alloc_wr got=%b want=1", rs1_busy); end
    alloc_en = 1'b1; alloc_reg = 5'd0;
    step();
    alloc_en = 1'b0; rs2 = 5'd0; #1;
    vectors++;
    if (rs2_busy !== 1'b0) begin errors++; $display("FAIL sb_x0 got=%b want=0", rs2_busy); end
  endtask
`endif

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_write_read();
    test_bypass_x0();
    test_back_to_back();
    test_soft_clear();
    test_restart();
`ifdef REGFILE_SCOREBOARD_EN
    test_scoreboard();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
